// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types, constants and edge-position helpers for the UART receiver control path
// Contents:
//   PS_WIDTH            width of the oversampling prescale value
//   DEFAULT_DATA_WIDTH  default number of data bits per frame
//   rx_state_e          receiver control states
//   edge_pos_t          mid / check / last edge positions within one bit
//   normalize_prescale  maps any prescale value onto a supported ratio (8, 16, 32)
//   edge_positions      derives the edge positions from a latched prescale
package uart_rx_pkg;

    localparam int PS_WIDTH           = 6;
    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    typedef struct packed {
        logic [PS_WIDTH-1:0] mid;
        logic [PS_WIDTH-1:0] chk;
        logic [PS_WIDTH-1:0] last;
    } edge_pos_t;

    // Unsupported ratios fall back to 8 so the counters always wrap.
    function automatic logic [PS_WIDTH-1:0] normalize_prescale(input logic [PS_WIDTH-1:0] ps);
        if (ps == PS_WIDTH'(16) || ps == PS_WIDTH'(32)) begin
            return ps;
        end
        return PS_WIDTH'(8);
    endfunction

    // The check edge sits two edges after mid, so the sampler's three
    // samples (mid-1..mid+1) are complete before any sub-block looks at them.
    function automatic edge_pos_t edge_positions(input logic [PS_WIDTH-1:0] ps);
        edge_pos_t pos;
        pos.mid  = ps >> 1;
        pos.chk  = (ps >> 1) + PS_WIDTH'(2);
        pos.last = ps - PS_WIDTH'(1);
        return pos;
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// rtl/uart_rx_edge_bit_counter.sv - oversampling edge counter, data bit counter and latched prescale
// Ports:
//   clock, reset        receiver clock, asynchronous active-low reset
//   capture_i           latch normalized prescale_i into ps (frame start)
//   prescale_i          raw prescale from the pin
//   edge_run_i          count edges; when low the edge counter is held at 0
//   edge_wrap_i         current edge is the last edge of the bit
//   bit_inc_i           advance the data bit index
//   bit_clear_i         clear the data bit index (has priority over bit_inc_i)
//   ps_o                latched prescale for the current frame
//   edge_count_o        edge index within the current bit
//   bit_count_o         data bit index
module edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int BIT_CNT_WIDTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     capture_i,
    input  logic [PS_WIDTH-1:0]      prescale_i,
    input  logic                     edge_run_i,
    input  logic                     edge_wrap_i,
    input  logic                     bit_inc_i,
    input  logic                     bit_clear_i,
    output logic [PS_WIDTH-1:0]      ps_o,
    output logic [PS_WIDTH-1:0]      edge_count_o,
    output logic [BIT_CNT_WIDTH-1:0] bit_count_o
);

    logic [PS_WIDTH-1:0]      ps_q, ps_d;
    logic [PS_WIDTH-1:0]      edge_q, edge_d;
    logic [BIT_CNT_WIDTH-1:0] bit_q, bit_d;

    always_comb begin
        ps_d   = capture_i ? normalize_prescale(prescale_i) : ps_q;
        edge_d = (edge_run_i && !edge_wrap_i) ? edge_q + PS_WIDTH'(1) : '0;
        bit_d  = bit_q;
        if (bit_clear_i) begin
            bit_d = '0;
        end else if (bit_inc_i) begin
            bit_d = bit_q + BIT_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ps_q   <= PS_WIDTH'(8);
            edge_q <= '0;
            bit_q  <= '0;
        end else begin
            ps_q   <= ps_d;
            edge_q <= edge_d;
            bit_q  <= bit_d;
        end
    end

    assign ps_o         = ps_q;
    assign edge_count_o = edge_q;
    assign bit_count_o  = bit_q;

endmodule

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - UART receiver control FSM: start detection, bit timing and sub-block strobes
// Ports:
//   clock, reset          oversampling clock, asynchronous active-low reset
//   rx_in                 serial line (idle high)
//   prescale              oversampling ratio (8, 16, 32; others act as 8)
//   parity_enable         frame carries a parity bit
//   start_glitch          start-check result (1 = start bit sampled high)
//   parity_error          parity-check result
//   stop_error            stop-check result
//   sample_enable         sampler window (edges mid-1..mid+1)
//   start_check_enable    one-cycle strobe in START at the check edge
//   deser_enable          one-cycle strobe in DATA at the check edge
//   parity_check_enable   one-cycle strobe in PARITY at the check edge
//   stop_check_enable     one-cycle strobe in STOP at the check edge
//   data_valid            one-cycle pulse after a clean frame
//   frame_error           one-cycle pulse after a parity or stop error
//   edge_count            edge index within the current bit
//   bit_count             data bit index
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          rx_in,
    input  logic [PS_WIDTH-1:0]           prescale,
    input  logic                          parity_enable,
    input  logic                          start_glitch,
    input  logic                          parity_error,
    input  logic                          stop_error,
    output logic                          sample_enable,
    output logic                          start_check_enable,
    output logic                          deser_enable,
    output logic                          parity_check_enable,
    output logic                          stop_check_enable,
    output logic                          data_valid,
    output logic                          frame_error,
    output logic [PS_WIDTH-1:0]           edge_count,
    output logic [$clog2(DATA_WIDTH):0]   bit_count
);

    localparam int BIT_CNT_WIDTH = $clog2(DATA_WIDTH) + 1;
    localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT = BIT_CNT_WIDTH'(DATA_WIDTH - 1);

    rx_state_e                state_q, state_d;
    logic                     parity_en_q, parity_en_d;
    logic                     data_valid_q, data_valid_d;
    logic                     frame_error_q, frame_error_d;

    logic                     capture, bit_inc, bit_clear;
    logic                     at_chk, at_end, frame_bad;
    logic [PS_WIDTH-1:0]      ps_q;
    logic [PS_WIDTH-1:0]      edge_cnt;
    logic [BIT_CNT_WIDTH-1:0] bit_cnt;
    edge_pos_t                pos;

    edge_bit_counter #(
        .BIT_CNT_WIDTH (BIT_CNT_WIDTH)
    ) u_counter (
        .clock        (clock),
        .reset        (reset),
        .capture_i    (capture),
        .prescale_i   (prescale),
        .edge_run_i   (state_q != ST_IDLE),
        .edge_wrap_i  (at_end),
        .bit_inc_i    (bit_inc),
        .bit_clear_i  (bit_clear),
        .ps_o         (ps_q),
        .edge_count_o (edge_cnt),
        .bit_count_o  (bit_cnt)
    );

    assign pos    = edge_positions(ps_q);
    assign at_chk = (edge_cnt == pos.chk);
    assign at_end = (edge_cnt == pos.last);

    // Parity errors only count when the frame was latched as carrying parity;
    // the parity checker's flag may hold a stale value from an earlier frame.
    assign frame_bad = stop_error | (parity_en_q & parity_error);

    always_comb begin
        state_d             = state_q;
        parity_en_d         = parity_en_q;
        data_valid_d        = 1'b0;
        frame_error_d       = 1'b0;
        capture             = 1'b0;
        bit_inc             = 1'b0;
        bit_clear           = 1'b1;
        start_check_enable  = 1'b0;
        deser_enable        = 1'b0;
        parity_check_enable = 1'b0;
        stop_check_enable   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rx_in) begin
                    state_d     = ST_START;
                    capture     = 1'b1;
                    parity_en_d = parity_enable;
                end
            end
            ST_START: begin
                start_check_enable = at_chk;
                if (at_end) begin
                    state_d = start_glitch ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                bit_clear    = 1'b0;
                deser_enable = at_chk;
                if (at_end) begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_clear = 1'b1;
                        state_d   = parity_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                parity_check_enable = at_chk;
                if (at_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                stop_check_enable = at_chk;
                if (at_end) begin
                    frame_error_d = frame_bad;
                    data_valid_d  = !frame_bad;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            parity_en_q   <= 1'b0;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            parity_en_q   <= parity_en_d;
            data_valid_q  <= data_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign sample_enable = (state_q != ST_IDLE)
                        && (edge_cnt >= pos.mid - PS_WIDTH'(1))
                        && (edge_cnt <= pos.mid + PS_WIDTH'(1));
    assign data_valid    = data_valid_q;
    assign frame_error   = frame_error_q;
    assign edge_count    = edge_cnt;
    assign bit_count     = bit_cnt;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb/tb_uart_rx_fsm.sv - scoreboard bench for uart_rx_fsm with directed and random frames
module tb_uart_rx_fsm;

    localparam int DW = 8;
    localparam int BW = $clog2(DW) + 1;

    localparam int K_SAMPLE = 0;
    localparam int K_START  = 1;
    localparam int K_DESER  = 2;
    localparam int K_PAR    = 3;
    localparam int K_STOP   = 4;
    localparam int K_DV     = 5;
    localparam int K_FE     = 6;

    typedef struct {
        int kind;
        int cyc;
        int edg;
        int bitc;
    } ev_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          rx_in = 1'b1;
    logic [5:0]    prescale = 6'd8;
    logic          parity_enable = 1'b0;
    logic          start_glitch = 1'b0;
    logic          parity_error = 1'b0;
    logic          stop_error = 1'b0;
    logic          sample_enable, start_check_enable, deser_enable;
    logic          parity_check_enable, stop_check_enable, data_valid, frame_error;
    logic [5:0]    edge_count;
    logic [BW-1:0] bit_count;

    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    int  next_free = 0;
    ev_t exp_q[$];
    bit  glitch_q[$];
    bit  perr_q[$];
    bit  serr_q[$];

    uart_rx_fsm #(.DATA_WIDTH(DW)) dut (
        .clock               (clock),
        .reset               (reset),
        .rx_in               (rx_in),
        .prescale            (prescale),
        .parity_enable       (parity_enable),
        .start_glitch        (start_glitch),
        .parity_error        (parity_error),
        .stop_error          (stop_error),
        .sample_enable       (sample_enable),
        .start_check_enable  (start_check_enable),
        .deser_enable        (deser_enable),
        .parity_check_enable (parity_check_enable),
        .stop_check_enable   (stop_check_enable),
        .data_valid          (data_valid),
        .frame_error         (frame_error),
        .edge_count          (edge_count),
        .bit_count           (bit_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("FAIL watchdog: got cycle %0d required finish before it", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int c, input int e, input int b);
        ev_t ev;
        ev.kind = kind;
        ev.cyc  = c;
        ev.edg  = e;
        ev.bitc = b;
        exp_q.push_back(ev);
    endtask

    function automatic int all_outputs();
        return int'({sample_enable, start_check_enable, deser_enable, parity_check_enable,
                     stop_check_enable, data_valid, frame_error, edge_count, bit_count});
    endfunction

    // Monitor: every cycle with an active strobe/pulse consumes one expected event.
    initial begin
        int  n;
        int  k;
        ev_t e;
        forever begin
            @(negedge clock);
            n = 0;
            k = -1;
            if (sample_enable)       begin n++; k = K_SAMPLE; end
            if (start_check_enable)  begin n++; k = K_START;  end
            if (deser_enable)        begin n++; k = K_DESER;  end
            if (parity_check_enable) begin n++; k = K_PAR;    end
            if (stop_check_enable)   begin n++; k = K_STOP;   end
            if (data_valid)          begin n++; k = K_DV;     end
            if (frame_error)         begin n++; k = K_FE;     end
            if (n > 1) check("outputs_overlap", n, 1);
            if (n >= 1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event_kind", k, -1);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", k, e.kind);
                    check("event_cycle", cyc, e.cyc);
                    check("event_edge", int'(edge_count), e.edg);
                    check("event_bit", int'(bit_count), e.bitc);
                end
            end
        end
    end

    // Stand-ins for the check sub-blocks: they register their result on the
    // clock after their enable strobe and hold it otherwise.
    initial begin
        bit sc, pc, tc;
        forever begin
            @(negedge clock);
            sc = start_check_enable;
            pc = parity_check_enable;
            tc = stop_check_enable;
            @(posedge clock);
            #1;
            if (sc) start_glitch = (glitch_q.size() > 0) ? glitch_q.pop_front() : 1'b0;
            if (pc) parity_error = (perr_q.size() > 0) ? perr_q.pop_front() : 1'b0;
            if (tc) stop_error   = (serr_q.size() > 0) ? serr_q.pop_front() : 1'b0;
        end
    end

    function automatic logic line_bit(input int b, input bit par, input logic [7:0] data);
        if (b == 0) return 1'b0;
        if (b <= DW) return data[b-1];
        if (par && b == DW + 1) return ^data;
        return 1'b1;
    endfunction

    task automatic run_frame(input int ps_raw, input bit par, input bit glitch, input bit perr,
                             input bit serr, input int gap, input logic [7:0] data,
                             input int ps_mid, input int abort_i);
        int p, mid, chk, n, s, target;
        p      = (ps_raw == 16 || ps_raw == 32) ? ps_raw : 8;
        mid    = p / 2;
        chk    = mid + 2;
        n      = glitch ? 1 : (DW + 2 + (par ? 1 : 0));
        target = ((next_free > cyc + 1) ? next_free : cyc + 1) + gap;
        s      = target + 1;

        glitch_q.push_back(glitch);
        if (!glitch) begin
            if (par) perr_q.push_back(perr);
            serr_q.push_back(serr);
        end
        for (int b = 0; b < n; b++) begin
            int base, kind, bc;
            base = s + b * p;
            if (b == 0)                   kind = K_START;
            else if (b <= DW)             kind = K_DESER;
            else if (par && b == DW + 1)  kind = K_PAR;
            else                          kind = K_STOP;
            bc = (kind == K_DESER) ? b - 1 : 0;
            for (int j = 0; j < 3; j++) push_ev(K_SAMPLE, base + mid - 1 + j, mid - 1 + j, bc);
            push_ev(kind, base + chk, chk, bc);
        end
        if (!glitch) push_ev((serr || (par && perr)) ? K_FE : K_DV, s + n * p, 0, 0);
        next_free = s + n * p;

        while (cyc < target) begin
            @(posedge clock);
            #1;
        end
        prescale      = ps_raw[5:0];
        parity_enable = par;
        for (int i = 0; i < (glitch ? 3 : n * p - 1); i++) begin
            rx_in = glitch ? 1'b0 : line_bit(i / p, par, data);
            if (i == 2) begin
                prescale      = ps_mid[5:0];
                parity_enable = ~par;
            end
            if (abort_i >= 0 && i == abort_i) begin
                @(negedge clock);
                #1;
                check("abort_point_edge", int'(edge_count), 5);
                check("abort_point_bit", int'(bit_count), 3);
                while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
                glitch_q.delete();
                perr_q.delete();
                serr_q.delete();
                reset = 1'b0;
                #1;
                check("reset_mid_frame_outputs", all_outputs(), 0);
                @(negedge clock);
                #1;
                check("reset_held_outputs", all_outputs(), 0);
                reset     = 1'b1;
                rx_in     = 1'b1;
                next_free = cyc + 1;
                return;
            end
            @(posedge clock);
            #1;
        end
        rx_in = 1'b1;
    endtask

    initial begin
        int sel, psr;
        repeat (2) @(negedge clock);
        #1;
        check("reset_outputs", all_outputs(), 0);
        @(negedge clock);
        #1;
        reset     = 1'b1;
        next_free = cyc + 1;

        //        ps  par gl perr serr gap data   ps_mid abort
        run_frame(8,  0,  0, 0,   0,   3,  8'h5A, 37,    -1);
        run_frame(16, 0,  1, 0,   0,   2,  8'h00, 8,     -1);
        run_frame(16, 1,  0, 1,   0,   1,  8'hC3, 32,    -1);
        run_frame(32, 0,  0, 0,   1,   0,  8'h81, 8,     -1);
        run_frame(8,  0,  0, 0,   0,   0,  8'h3C, 16,    -1);
        run_frame(16, 0,  0, 0,   0,   0,  8'hE7, 8,     -1);
        run_frame(16, 1,  0, 0,   0,   0,  8'h55, 16,    -1);
        run_frame(21, 0,  0, 1,   0,   1,  8'h0F, 32,    -1);
        run_frame(8,  0,  0, 0,   0,   2,  8'hA5, 16,    38);
        run_frame(8,  0,  0, 0,   0,   0,  8'h5A, 16,    -1);

        for (int r = 0; r < 20; r++) begin
            sel = $urandom_range(0, 3);
            psr = (sel == 0) ? 8 : (sel == 1) ? 16 : (sel == 2) ? 32 : $urandom_range(0, 63);
            run_frame(psr, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                      $urandom_range(0, 3), 8'($urandom), $urandom_range(0, 63), -1);
        end

        while (cyc < next_free + 4) @(negedge clock);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
